// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the result-RAM access controller.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 64;
    localparam int RES_W_DEF  = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2,
        ST_RD    = 2'd3
    } state_t;

    // Who received the most recent grant; the arbiter favours the other side on a tie.
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_IDX_WR = 0;
    localparam int GNT_IDX_RD = 1;

endpackage

// File: rtl/mem_ctrl_if.sv
// Result-write and host-read channels of the controller.
// master = compute core / host side, slave = controller side.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF
);
    logic              res_valid;
    logic [RES_W-1:0]  res_data;
    logic              res_ready;

    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_rvalid;
    logic [DATA_W-1:0] rd_rdata;

    modport master (
        output res_valid, res_data, rd_valid, rd_addr,
        input  res_ready, rd_ready, rd_rvalid, rd_rdata
    );

    modport slave (
        input  res_valid, res_data, rd_valid, rd_addr,
        output res_ready, rd_ready, rd_rvalid, rd_rdata
    );

endinterface

// File: rtl/mem_ctrl_arb.sv
// Two-requester round-robin arbiter (write vs. read) for the shared RAM port.
// Grants only while the controller is idle; a grant is always consumed the same
// edge, so last_grant simply records whichever side was granted.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       idle,
    input  logic       req_wr,
    input  logic       req_rd,
    output logic [1:0] gnt
);

    grant_t last_grant;

    // One-hot grant: single requester wins outright, a tie goes to the side not served last.
    always_comb begin
        gnt = '0;
        if (idle) begin
            if (req_wr && req_rd) begin
                if (last_grant == GNT_WR) gnt[GNT_IDX_RD] = 1'b1;
                else                      gnt[GNT_IDX_WR] = 1'b1;
            end else if (req_wr) begin
                gnt[GNT_IDX_WR] = 1'b1;
            end else if (req_rd) begin
                gnt[GNT_IDX_RD] = 1'b1;
            end
        end
    end

    // Remember the side served most recently; starts as write so a read wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_WR;
        end else if (gnt[GNT_IDX_WR]) begin
            last_grant <= GNT_WR;
        end else if (gnt[GNT_IDX_RD]) begin
            last_grant <= GNT_RD;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port access controller in front of the 256x64 result RAM.
// Stores each 128-bit result as two words at consecutive addresses and
// services host reads; both share the RAM port under round-robin arbitration.
// Build option MEM_CTRL_WRAP_EN: the result region is a circular buffer and
// full never asserts. Without it, full is sticky once wr_ptr wraps to 0.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | RAM idle, arbitration open, rd_pend shows read data
// ST_WR_LO | writing low result word at the latched wr_ptr
// ST_WR_HI | writing high result word at wr_ptr+1
// ST_RD    | RAM read strobe for the accepted host address
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_if.slave         bus,
    input  logic              clr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              full,
    output logic              cen,
    output logic              wen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_din,
    input  logic [DATA_W-1:0] s_dout
);

    state_t            state;
    logic [DATA_W-1:0] res_hi;
    logic              rd_pend;
    logic              req_wr;
    logic              req_rd;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] ptr_next;

    assign req_wr   = bus.res_valid & ~full & ~clr;
    assign req_rd   = bus.rd_valid;
    assign ptr_next = wr_ptr + ADDR_W'(2);

    mem_ctrl_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .idle   (state == ST_IDLE),
        .req_wr (req_wr),
        .req_rd (req_rd),
        .gnt    (gnt)
    );

    assign bus.res_ready = gnt[GNT_IDX_WR];
    assign bus.rd_ready  = gnt[GNT_IDX_RD];
    assign bus.rd_rvalid = rd_pend;
    // The RAM already clears its output on non-read edges, so data passes straight through.
    assign bus.rd_rdata  = s_dout;

    // Main sequencer: RAM strobes, address/data registers and the write pointer.
    // The high-word address comes from s_addr rather than wr_ptr so that a clr
    // arriving mid-write cannot redirect the second word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cen     <= 1'b0;
            wen     <= 1'b0;
            s_addr  <= '0;
            s_din   <= '0;
            res_hi  <= '0;
            wr_ptr  <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt[GNT_IDX_WR]) begin
                        state  <= ST_WR_LO;
                        cen    <= 1'b1;
                        wen    <= 1'b1;
                        s_addr <= wr_ptr;
                        s_din  <= bus.res_data[DATA_W-1:0];
                        res_hi <= bus.res_data[RES_W-1:DATA_W];
                    end else if (gnt[GNT_IDX_RD]) begin
                        state  <= ST_RD;
                        cen    <= 1'b1;
                        wen    <= 1'b0;
                        s_addr <= bus.rd_addr;
                    end
                end
                ST_WR_LO: begin
                    state  <= ST_WR_HI;
                    s_addr <= s_addr + ADDR_W'(1);
                    s_din  <= res_hi;
                end
                ST_WR_HI: begin
                    state  <= ST_IDLE;
                    cen    <= 1'b0;
                    wen    <= 1'b0;
                    wr_ptr <= ptr_next;
                end
                ST_RD: begin
                    state   <= ST_IDLE;
                    cen     <= 1'b0;
                    wen     <= 1'b0;
                    rd_pend <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    cen   <= 1'b0;
                    wen   <= 1'b0;
                end
            endcase
            if (clr) begin
                wr_ptr <= '0;
            end
        end
    end

`ifdef MEM_CTRL_WRAP_EN
    assign full = 1'b0;
`else
    logic full_q;

    // Sticky full: set when the pointer wraps back to 0, cleared only by clr or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
        end else if (clr) begin
            full_q <= 1'b0;
        end else if (state == ST_WR_HI && ptr_next == '0) begin
            full_q <= 1'b1;
        end
    end

    assign full = full_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: randomized traffic checked against an
// address-level model of the result region, plus directed corner cases.
module tb_mem_ctrl;

`ifdef MEM_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  wr_ptr;
    logic        full;
    logic        cen;
    logic        wen;
    logic [7:0]  s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout = '0;
    logic [63:0] ram [256] = '{default: '0};

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .clr    (clr),
        .wr_ptr (wr_ptr),
        .full   (full),
        .cen    (cen),
        .wen    (wen),
        .s_addr (s_addr),
        .s_din  (s_din),
        .s_dout (s_dout)
    );

    always #5 clk = ~clk;

    // RAM: one-cycle registered read, output cleared on any non-read edge.
    always @(posedge clk) begin
        if (cen && wen) ram[s_addr] <= s_din;
        if (cen && !wen) s_dout <= ram[s_addr];
        else             s_dout <= '0;
    end

    // Reference model of the result region.
    logic [63:0] exp_mem [256] = '{default: '0};
    int          exp_ptr  = 0;
    bit          exp_full = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [127:0] d);
        exp_mem[exp_ptr]             = d[63:0];
        exp_mem[(exp_ptr + 1) % 256] = d[127:64];
        exp_ptr = (exp_ptr + 2) % 256;
        if (!WRAP && exp_ptr == 0) exp_full = 1'b1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.res_valid = 1'b0;
        bus.rd_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_ptr  = 0;
        exp_full = 1'b0;
    endtask

    task automatic check_status(input string tag);
        repeat (3) @(negedge clk);
        check_eq({tag, "_ptr"}, wr_ptr, 8'(exp_ptr));
        check_eq({tag, "_full"}, full, exp_full);
    endtask

    task automatic do_write(input logic [127:0] d);
        int   n;
        logic got;
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_data  = d;
        #1;
        got = bus.res_ready;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            #1;
            got = bus.res_ready;
            n++;
        end
        check_eq("wr_accept", got, 1);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        if (got) model_write(d);
    endtask

    task automatic do_read(input logic [7:0] a);
        int   n;
        int   lat;
        logic got;
        logic seen;
        @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = a;
        #1;
        got = bus.rd_ready;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            #1;
            got = bus.rd_ready;
            n++;
        end
        check_eq("rd_accept", got, 1);
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.rd_rvalid) begin
                seen = 1'b1;
                lat  = k;
                check_eq("rd_data", bus.rd_rdata, exp_mem[a]);
            end
        end
        check_eq("rd_latency", lat, 2);
        @(negedge clk);
        check_eq("rd_rvalid_pulse", bus.rd_rvalid, 0);
        check_eq("rd_rdata_clr", bus.rd_rdata, 0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam int NC = 26;

    initial begin
        logic [127:0] d1;
        logic [127:0] d2;
        logic [127:0] dc;
        logic [127:0] last_d;
        logic         got;
        bit           exp_rd [NC];
        bit           exp_wr [NC];
        bit           exp_rv [NC];

        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.rd_valid  = 1'b0;
        bus.rd_addr   = '0;

        // Reset state.
        apply_reset();
        @(negedge clk);
        check_eq("rst_cen", cen, 0);
        check_eq("rst_wen", wen, 0);
        check_eq("rst_s_addr", s_addr, 0);
        check_eq("rst_s_din", s_din, 0);
        check_eq("rst_wr_ptr", wr_ptr, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_res_ready", bus.res_ready, 0);
        check_eq("rst_rd_ready", bus.rd_ready, 0);
        check_eq("rst_rd_rvalid", bus.rd_rvalid, 0);
        check_eq("rst_rd_rdata", bus.rd_rdata, 0);

        // Directed write then read, and an unwritten address.
        do_write(128'h0000000000000002_0000000000000078);
        check_status("wr1");
        check_eq("ram0", ram[0], 64'h78);
        check_eq("ram1", ram[1], 64'h2);
        do_read(8'd0);
        do_read(8'd1);
        do_read(8'h80);

        // Randomized mix of writes and reads.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                do_write(rand128());
                if ($urandom_range(0, 3) == 0) check_status("rnd_wr");
            end else begin
                if ($urandom_range(0, 1) == 0) do_read(8'($urandom_range(0, 31)));
                else                          do_read(8'($urandom_range(0, 255)));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        check_status("rnd_end");

        // Contention from reset: reads win the first tie, then grants alternate.
        for (int c = 0; c < NC; c++) begin
            exp_rd[c] = 1'b0;
            exp_wr[c] = 1'b0;
            exp_rv[c] = 1'b0;
        end
        begin
            int  t;
            bit  rd_turn;
            t       = 0;
            rd_turn = 1'b1;
            while (t < NC) begin
                if (rd_turn) begin
                    exp_rd[t] = 1'b1;
                    if (t + 2 < NC) exp_rv[t + 2] = 1'b1;
                    t += 2;
                end else begin
                    exp_wr[t] = 1'b1;
                    t += 3;
                end
                rd_turn = !rd_turn;
            end
        end
        dc = rand128();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = 8'h40;
        bus.res_valid = 1'b1;
        bus.res_data  = dc;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_ptr  = 0;
        exp_full = 1'b0;
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            check_eq($sformatf("cont_rd_ready_%0d", c), bus.rd_ready, exp_rd[c]);
            check_eq($sformatf("cont_res_ready_%0d", c), bus.res_ready, exp_wr[c]);
            check_eq($sformatf("cont_rvalid_%0d", c), bus.rd_rvalid, exp_rv[c]);
            if (exp_rv[c]) check_eq("cont_rdata", bus.rd_rdata, exp_mem[8'h40]);
            if (exp_wr[c]) model_write(dc);
        end
        @(posedge clk);
        #1;
        bus.rd_valid  = 1'b0;
        bus.res_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_status("cont");
        do_read(8'd0);
        do_read(8'd1);

        // Reset asserted while the high word is being written.
        apply_reset();
        d1 = rand128();
        do_write(d1);
        check_status("pre_abort");
        d2 = rand128();
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_data  = d2;
        #1;
        got = bus.res_ready;
        check_eq("abort_accept", got, 1);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_cen", cen, 0);
        check_eq("abort_wen", wen, 0);
        check_eq("abort_wr_ptr", wr_ptr, 0);
        if (got) exp_mem[2] = d2[63:0];
        exp_ptr  = 0;
        exp_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        do_write(rand128());
        check_status("post_abort");
        do_read(8'd0);
        do_read(8'd1);
        do_read(8'd2);
        do_read(8'd3);

        // Filling the whole region: sticky full, or circular wrap.
        apply_reset();
        last_d = '0;
`ifdef MEM_CTRL_WRAP_EN
        for (int i = 0; i < 129; i++) begin
            last_d = rand128();
            do_write(last_d);
        end
        check_status("wrap");
        check_eq("wrap_ram0", ram[0], last_d[63:0]);
        check_eq("wrap_ram1", ram[1], last_d[127:64]);
        do_read(8'd0);
        do_read(8'd1);
        do_read(8'd254);
`else
        for (int i = 0; i < 128; i++) begin
            last_d = rand128();
            do_write(last_d);
        end
        check_status("fill");
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_data  = rand128();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("full_blocks_ready", bus.res_ready, 0);
        end
        do_read(8'd254);
        check_eq("full_last_hi", ram[255], last_d[127:64]);
        @(negedge clk);
        bus.res_valid = 1'b0;
`endif
        // clr with a pending result: no accept while clr is high, then pointer and full cleared.
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_data  = rand128();
        clr           = 1'b1;
        #1;
        check_eq("clr_blocks_ready", bus.res_ready, 0);
        @(posedge clk);
        #1;
        clr           = 1'b0;
        bus.res_valid = 1'b0;
        exp_ptr  = 0;
        exp_full = 1'b0;
        check_status("clr");
        do_write(rand128());
        check_status("post_clr");
        do_read(8'd0);
        do_read(8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
